// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial Mealy sequence detector with reloadable pattern and saturating match counter
module seq_detect_param #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [WIDTH-1:0] pat_in,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int             FW   = $clog2(WIDTH);
    localparam logic [FW-1:0] FULL = FW'(WIDTH - 1);
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-2:0] hist;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;
    // candidate window is the stored history followed by the bit on the wire
    always_comb begin
        cand     = {hist, x};
        z        = x_valid & ~pat_load & ~rst & (fill == FULL) & (cand == pat);
        fill_nxt = (z & ~overlap) ? '0 : (fill == FULL) ? FULL : fill + 1'b1;
        cnt_sat  = &match_cnt;
    end
    // pattern, history, fill level, delayed match and saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pat       <= PATTERN;
            hist      <= '0;
            fill      <= '0;
            z_q       <= 1'b0;
            match_cnt <= '0;
        end else begin
            z_q       <= z;
            match_cnt <= (z & ~cnt_sat) ? match_cnt + 1'b1 : match_cnt;
            if (pat_load) begin
                pat  <= pat_in;
                fill <= '0;
            end else if (x_valid) begin
                hist <= cand[WIDTH-2:0];
                fill <= fill_nxt;
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench driving directed streams into a default and a saturating-counter instance
module tb_seq_detect_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0;
    logic       z0, zq0, sat0, z1, zq1, sat1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    seq_detect_param dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
        .z(z0), .z_q(zq0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1111), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in),
        .z(z1), .z_q(zq1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic z;
        logic zq;
        int   cnt;
        bit   all;
        int   sel;
        int   tid;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tid = 0;
    int   cur_sel = 0;
    logic exp_zq = 1'b0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input int t, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL test%0d %s: got %0d expected %0d at %0t", t, name, act, req, $time);
        end
    endtask

    // monitor: every cycle with a pending expectation, compare the selected instance
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int   maxc;
            e    = q.pop_front();
            maxc = e.sel ? 3 : 255;
            chk("z", e.tid, int'(e.sel ? z1 : z0), int'(e.z));
            if (e.all) begin
                chk("z_q", e.tid, int'(e.sel ? zq1 : zq0), int'(e.zq));
                chk("match_cnt", e.tid, e.sel ? int'(cnt1) : int'(cnt0), e.cnt);
                chk("cnt_sat", e.tid, int'(e.sel ? sat1 : sat0), int'(e.cnt == maxc));
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic xi, input logic pl,
                        input logic [3:0] pi, input logic ez);
        int maxc;
        maxc = cur_sel ? 3 : 255;
        @(posedge clk);
        #1;
        rst      = r;
        x_valid  = v;
        x        = xi;
        pat_load = pl;
        pat_in   = pi;
        q.push_back('{ez, exp_zq, exp_cnt, !r, cur_sel, tid});
        if (r) begin
            exp_zq  = 1'b0;
            exp_cnt = 0;
        end else begin
            exp_zq = ez;
            if (ez && exp_cnt < maxc) exp_cnt++;
        end
    endtask

    // s: '0'/'1' valid bits, '-' invalid cycle with toggling x; m: '1' where z is expected
    task automatic run(input string s, input string m);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "-") step(1'b0, 1'b0, i[0], 1'b0, 4'b0, 1'b0);
            else step(1'b0, 1'b1, s[i] == "1", 1'b0, 4'b0, m[i] == "1");
        end
    endtask

    initial begin
        tid = 1;
        overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        run("0101101101101", "0000100100100");
        tid = 2;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        overlap = 1'b0;
        run("0101101101101", "0000100000100");
        tid = 3;
        overlap = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        run("10---11", "0000001");
        tid = 4;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        run("101", "000");
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
        run("0110", "0001");
        tid = 6;
        run("101", "000");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0);
        run("1", "0");
        run("1011", "0001");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        tid = 5;
        cur_sel = 1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        run("11111111", "00011111");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
